// File: rtl/mc_datapath_hs_pkg.sv
// Shared declarations for the parametrised multicycle MIPS datapath:
// instruction field encodings, ALU control codes and memory FSM states.
package mips_decls_p;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    FN_ADD = 6'h20,
    FN_SUB = 6'h22,
    FN_AND = 6'h24,
    FN_OR  = 6'h25,
    FN_SLT = 6'h2A
  } funct_t;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_REQ  = 2'd1,
    MS_DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mc_datapath_hs_lib.sv
// Datapath building blocks: enabled flop, muxes, ALU and a parametrised
// register file with a hard-wired zero register.
module flopenr #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q <= '0;
    else if (en)   q <= d;
  end
endmodule

module mux2 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);
  assign y = s ? d1 : d0;
endmodule

module mux3 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] y
);
  assign y = s[1] ? d2 : (s[0] ? d1 : d0);
endmodule

module mux4 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = d0;
    case (s)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end
endmodule

module alu
  import mips_decls_p::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alucontrol,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  always_comb begin
    result = '0;
    case (alu_op_t'(alucontrol))
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
endmodule

module regfile_p #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] ra1,
  input  logic [$clog2(NREGS)-1:0] ra2,
  input  logic [$clog2(NREGS)-1:0] wa,
  input  logic [WIDTH-1:0]         wd,
  output logic [WIDTH-1:0]         rd1,
  output logic [WIDTH-1:0]         rd2
);
  logic [WIDTH-1:0] rf [NREGS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (we && (wa != '0)) begin
      rf[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : rf[ra1];
  assign rd2 = (ra2 == '0) ? '0 : rf[ra2];
endmodule

// File: rtl/mc_datapath_hs_mem_hs_fsm.sv
// Valid/ready memory handshake: IDLE -> REQ (wait states, timeout) -> DONE,
// with a sticky timeout flag and a read-completion strobe for IR/MDR capture.
module mem_hs_fsm
  import mips_decls_p::*;
#(
  parameter int unsigned MAXWAIT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic memstart,
  input  logic memwrite,
  input  logic mem_ready,
  output logic stall,
  output logic mem_req,
  output logic mem_we,
  output logic rd_done,
  output logic memerr
);
  localparam int unsigned CW = $clog2(MAXWAIT + 1);

  mem_state_t    state, state_nxt;
  logic          we_q;
  logic          timeout;
  logic [CW-1:0] cnt, cnt_nxt;

  assign cnt_nxt = cnt + CW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= MS_IDLE;
    else          state <= state_nxt;
  end

  // stall rises combinationally with memstart so the controller holds state
  // in the very cycle it issues the request.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    rd_done   = 1'b0;
    timeout   = 1'b0;
    case (state)
      MS_IDLE: begin
        if (memstart) begin
          stall     = 1'b1;
          state_nxt = MS_REQ;
        end
      end
      MS_REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        mem_we  = we_q;
        if (mem_ready) begin
          rd_done   = ~we_q;
          state_nxt = MS_DONE;
        end else if (cnt_nxt == CW'(MAXWAIT)) begin
          timeout   = 1'b1;
          state_nxt = MS_DONE;
        end
      end
      MS_DONE: state_nxt = MS_IDLE;
      default: state_nxt = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q   <= 1'b0;
      cnt    <= '0;
      memerr <= 1'b0;
    end else begin
      if (state == MS_IDLE && memstart) begin
        we_q <= memwrite;
        cnt  <= '0;
      end else if (state == MS_REQ && !mem_ready) begin
        cnt <= cnt_nxt;
      end
      if (timeout) memerr <= 1'b1;
    end
  end
endmodule

// File: rtl/mc_datapath_hs.sv
// Parametrised multicycle MIPS datapath with a valid/ready memory handshake,
// selectable sign/zero immediate extension and a stall output to the controller.
module mc_datapath_hs
  import mips_decls_p::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NREGS   = 32,
  parameter int unsigned MAXWAIT = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pcen,
  input  logic             irwrite,
  input  logic             regwrite,
  input  logic             alusrca,
  input  logic             iord,
  input  logic             memtoreg,
  input  logic             regdst,
  input  logic             extop,
  input  logic [1:0]       alusrcb,
  input  logic [1:0]       pcsrc,
  input  logic [2:0]       alucontrol,
  input  logic             memstart,
  input  logic             memwrite,
  output logic [5:0]       opcode,
  output logic [5:0]       funct,
  output logic             zero,
  output logic             stall,
  output logic             memerr,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] readdata,
  input  logic             mem_ready
);
  localparam int unsigned RAW = $clog2(NREGS);

  logic [WIDTH-1:0] pc, pcnext, instr, mdr;
  logic [WIDTH-1:0] rd1, rd2, a, b;
  logic [WIDTH-1:0] srca, srcb, aluresult, aluout;
  logic [WIDTH-1:0] immext, immsh, wd, jtarget;
  logic [RAW-1:0]   ra1, ra2, wa;
  logic             rd_done, pc_en, ir_en, rf_we;

  mem_hs_fsm #(.MAXWAIT(MAXWAIT)) u_mem (
    .clk       (clk),
    .reset_n   (reset_n),
    .memstart  (memstart),
    .memwrite  (memwrite),
    .mem_ready (mem_ready),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .rd_done   (rd_done),
    .memerr    (memerr)
  );

  // Controller may keep pcen/regwrite asserted through a stall; they only
  // take effect once the access has completed.
  assign pc_en = pcen & ~stall;
  assign rf_we = regwrite & ~stall;
  assign ir_en = rd_done & irwrite;

  flopenr #(.WIDTH(WIDTH)) u_pc   (.clk(clk), .reset_n(reset_n), .en(pc_en),   .d(pcnext),    .q(pc));
  flopenr #(.WIDTH(WIDTH)) u_ir   (.clk(clk), .reset_n(reset_n), .en(ir_en),   .d(readdata),  .q(instr));
  flopenr #(.WIDTH(WIDTH)) u_mdr  (.clk(clk), .reset_n(reset_n), .en(rd_done), .d(readdata),  .q(mdr));
  flopenr #(.WIDTH(WIDTH)) u_a    (.clk(clk), .reset_n(reset_n), .en(1'b1),    .d(rd1),       .q(a));
  flopenr #(.WIDTH(WIDTH)) u_b    (.clk(clk), .reset_n(reset_n), .en(1'b1),    .d(rd2),       .q(b));
  flopenr #(.WIDTH(WIDTH)) u_aout (.clk(clk), .reset_n(reset_n), .en(1'b1),    .d(aluresult), .q(aluout));

  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];
  assign writedata = b;

  assign ra1 = instr[21 +: RAW];
  assign ra2 = instr[16 +: RAW];

  mux2 #(.WIDTH(RAW))   u_wamux (.d0(instr[16 +: RAW]), .d1(instr[11 +: RAW]), .s(regdst),   .y(wa));
  mux2 #(.WIDTH(WIDTH)) u_wdmux (.d0(aluout),           .d1(mdr),              .s(memtoreg), .y(wd));
  mux2 #(.WIDTH(WIDTH)) u_adr   (.d0(pc),               .d1(aluout),           .s(iord),     .y(adr));

  regfile_p #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
    .clk(clk), .reset_n(reset_n), .we(rf_we),
    .ra1(ra1), .ra2(ra2), .wa(wa), .wd(wd),
    .rd1(rd1), .rd2(rd2)
  );

  always_comb begin
    immext = {{(WIDTH-16){instr[15]}}, instr[15:0]};
    if (extop) immext = {{(WIDTH-16){1'b0}}, instr[15:0]};
  end

  assign immsh   = {immext[WIDTH-3:0], 2'b00};
  assign jtarget = {pc[WIDTH-1:28], instr[25:0], 2'b00};

  mux2 #(.WIDTH(WIDTH)) u_srca (.d0(pc), .d1(a), .s(alusrca), .y(srca));
  mux4 #(.WIDTH(WIDTH)) u_srcb (.d0(b), .d1(WIDTH'(4)), .d2(immext), .d3(immsh), .s(alusrcb), .y(srcb));

  alu #(.WIDTH(WIDTH)) u_alu (.a(srca), .b(srcb), .alucontrol(alucontrol), .result(aluresult), .zero(zero));

  mux3 #(.WIDTH(WIDTH)) u_pcmux (.d0(aluresult), .d1(aluout), .d2(jtarget), .s(pcsrc), .y(pcnext));
endmodule

// File: tb/tb_mc_datapath_hs.sv
// Directed bench for mc_datapath_hs: a 32-bit instance for handshake and
// datapath behaviour, plus a 64-bit/16-register instance for the wide ADD wrap.
module tb_mc_datapath_hs;
  logic        clk = 1'b0;
  logic        reset_n, reset_n2;
  logic        pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst, extop;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  alucontrol;
  logic        memstart, memwrite, mem_ready;
  logic [31:0] readdata;
  logic [63:0] readdata2;

  logic [5:0]  opcode, funct;
  logic        zero, stall, memerr, mem_req, mem_we;
  logic [31:0] adr, writedata;

  logic [5:0]  opcode_w, funct_w;
  logic        zero_w, stall_w, memerr_w, mem_req_w, mem_we_w;
  logic [63:0] adr_w, writedata_w;

  int checks = 0;
  int errors = 0;

  assign readdata2 = {32'h0, readdata};

  always #5 clk = ~clk;

  mc_datapath_hs #(.WIDTH(32), .NREGS(32), .MAXWAIT(15)) dut (
    .clk(clk), .reset_n(reset_n), .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .extop(extop),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .memstart(memstart), .memwrite(memwrite),
    .opcode(opcode), .funct(funct), .zero(zero), .stall(stall), .memerr(memerr),
    .mem_req(mem_req), .mem_we(mem_we), .adr(adr), .writedata(writedata),
    .readdata(readdata), .mem_ready(mem_ready)
  );

  mc_datapath_hs #(.WIDTH(64), .NREGS(16), .MAXWAIT(15)) dut_w (
    .clk(clk), .reset_n(reset_n2), .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .extop(extop),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .memstart(memstart), .memwrite(memwrite),
    .opcode(opcode_w), .funct(funct_w), .zero(zero_w), .stall(stall_w), .memerr(memerr_w),
    .mem_req(mem_req_w), .mem_we(mem_we_w), .adr(adr_w), .writedata(writedata_w),
    .readdata(readdata2), .mem_ready(mem_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] word);
    iord = 1'b0; memstart = 1'b1; memwrite = 1'b0; irwrite = 1'b1;
    readdata = word; mem_ready = 1'b1;
    tick();
    memstart = 1'b0;
    tick();
    mem_ready = 1'b0; irwrite = 1'b0;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; reset_n2 = 1'b0;
    pcen = 0; irwrite = 0; regwrite = 0; alusrca = 0; iord = 0; memtoreg = 0;
    regdst = 0; extop = 0; alusrcb = 2'b00; pcsrc = 2'b00; alucontrol = 3'b010;
    memstart = 0; memwrite = 0; mem_ready = 0; readdata = '0;
    tick(); tick();
    check("rst_adr", adr, 0);
    check("rst_stall", stall, 0);
    check("rst_req", mem_req, 0);
    check("rst_err", memerr, 0);
    check("rst_op", opcode, 0);
    check("rst_wd", writedata, 0);
    reset_n = 1'b1;

    // reset asserted in the middle of a pending request
    memstart = 1; irwrite = 1; readdata = 32'hDEADBEEF; mem_ready = 0;
    tick();
    memstart = 0;
    check("abort_req_pre", mem_req, 1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_req", mem_req, 0);
    check("abort_stall", stall, 0);
    check("abort_pc", adr, 0);
    check("abort_ir", opcode, 0);
    tick();
    reset_n = 1'b1; irwrite = 0;

    // zero-wait fetch, pcen held high through the stall
    pcen = 1; alusrcb = 2'b01; alucontrol = 3'b010;
    memstart = 1; irwrite = 1; readdata = 32'h20080005; mem_ready = 1;
    #1 check("zw_stall0", stall, 1);
    tick();
    memstart = 0;
    check("zw_stall1", stall, 1);
    check("zw_adr", adr, 0);
    check("zw_we", mem_we, 0);
    tick();
    check("zw_stall2", stall, 0);
    check("zw_op", opcode, 6'h08);
    check("zw_funct", funct, 6'h05);
    check("zw_pc_held", adr, 0);
    mem_ready = 0; irwrite = 0;
    tick();
    pcen = 0;
    check("zw_pc4", adr, 4);

    // fetch with three wait states
    memstart = 1; irwrite = 1; readdata = 32'hFFFFFFFF; mem_ready = 0;
    tick();
    memstart = 0;
    for (int i = 0; i < 3; i++) begin
      check("ws_req", mem_req, 1);
      check("ws_adr", adr, 4);
      check("ws_ir", opcode, 6'h08);
      tick();
    end
    readdata = 32'h3409FFFF; mem_ready = 1;
    check("ws_req4", mem_req, 1);
    check("ws_adr4", adr, 4);
    tick();
    check("ws_op", opcode, 6'h0D);
    check("ws_req_off", mem_req, 0);
    mem_ready = 0; irwrite = 0;
    tick();

    // ori $9,$0,0xFFFF with zero extension
    iord = 1; alusrca = 1; alusrcb = 2'b10; extop = 1; alucontrol = 3'b001;
    tick();
    check("ori_alu", adr, 32'h0000FFFF);
    regwrite = 1; tick(); regwrite = 0; tick();
    check("ori_rt", writedata, 32'h0000FFFF);

    // addi $9,$0,-1 with sign extension
    do_fetch(32'h2009FFFF);
    iord = 1; alusrca = 1; alusrcb = 2'b10; extop = 0; alucontrol = 3'b010;
    tick();
    check("addi_alu", adr, 32'hFFFFFFFF);
    regwrite = 1; tick(); regwrite = 0; tick();
    check("addi_rt", writedata, 32'hFFFFFFFF);

    // ori $0,$0,0x1234 must leave $0 reading zero
    do_fetch(32'h34001234);
    iord = 1; alusrca = 1; alusrcb = 2'b10; extop = 1; alucontrol = 3'b001;
    tick();
    check("r0_alu", adr, 32'h00001234);
    regwrite = 1; tick(); regwrite = 0; tick();
    check("r0_read", writedata, 0);

    // addi $10,$0,1 then slt $11,$9,$10
    do_fetch(32'h200A0001);
    iord = 1; alusrca = 1; alusrcb = 2'b10; extop = 0; alucontrol = 3'b010;
    tick();
    regwrite = 1; tick(); regwrite = 0;
    do_fetch(32'h012A582A);
    iord = 1; alusrca = 1; alusrcb = 2'b00; alucontrol = 3'b111;
    #1 check("slt_zero", zero, 0);
    check("slt_funct", funct, 6'h2A);
    tick();
    check("slt_res", adr, 1);

    // sub $11,$9,$9 then load $11 from MDR
    do_fetch(32'h01295822);
    iord = 1; alusrca = 1; alusrcb = 2'b00; alucontrol = 3'b110;
    #1 check("sub_zero", zero, 1);
    tick();
    check("sub_res", adr, 0);
    regdst = 1; memtoreg = 1; regwrite = 1; tick();
    regwrite = 0; regdst = 0; memtoreg = 0;

    // sw $11,0($0): latched write strobe, no IR capture on a store
    do_fetch(32'hAC0B0000);
    check("sw_wd", writedata, 32'h01295822);
    iord = 1; alusrca = 1; alusrcb = 2'b10; extop = 0; alucontrol = 3'b010;
    tick();
    memstart = 1; memwrite = 1; irwrite = 1; readdata = 32'hFFFFFFFF; mem_ready = 0;
    tick();
    memstart = 0; memwrite = 0;
    check("sw_we", mem_we, 1);
    check("sw_adr", adr, 0);
    mem_ready = 1;
    tick();
    check("sw_ir", opcode, 6'h2B);
    mem_ready = 0; irwrite = 0;
    tick();

    // jump to {pc[31:28], instr[25:0], 00}
    iord = 0; pcsrc = 2'b10; pcen = 1;
    tick();
    pcen = 0; pcsrc = 2'b00;
    check("jmp_pc", adr, 32'h002C0000);

    // timeout after MAXWAIT wait cycles, sticky until reset
    memstart = 1; irwrite = 1; readdata = 32'h12345678; mem_ready = 0;
    tick();
    memstart = 0;
    for (int i = 0; i < 15; i++) begin
      check("to_req", mem_req, 1);
      check("to_err_low", memerr, 0);
      tick();
    end
    check("to_err", memerr, 1);
    check("to_req_off", mem_req, 0);
    check("to_ir", opcode, 6'h2B);
    irwrite = 0;
    tick(); tick(); tick();
    check("to_sticky", memerr, 1);
    reset_n = 1'b0;
    #1;
    check("to_clear", memerr, 0);
    check("rst2_pc", adr, 0);
    tick();
    reset_n = 1'b1; reset_n2 = 1'b1;

    // 64-bit / 16-register instance: all-ones + 1 wraps to zero
    do_fetch(32'h2001FFFF);
    iord = 1; alusrca = 1; alusrcb = 2'b10; extop = 0; alucontrol = 3'b010;
    tick();
    check("w64_ones", adr_w, 64'hFFFF_FFFF_FFFF_FFFF);
    regwrite = 1; tick(); regwrite = 0;
    do_fetch(32'h20220001);
    iord = 1; alusrca = 1; alusrcb = 2'b10; extop = 0; alucontrol = 3'b010;
    #1 check("w64_zero", zero_w, 1);
    check("w64_op", opcode_w, 6'h08);
    check("w64_funct", funct_w, 6'h01);
    check("w64_wd", writedata_w, 0);
    check("w64_idle", {memerr_w, stall_w, mem_req_w, mem_we_w}, 0);
    tick();
    check("w64_sum", adr_w, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_datapath_hs.md
Name: mc_datapath_hs

Overview:
- Parametrised multicycle MIPS datapath, successor to the fixed 32-bit datapath.
- Data width and register-file depth are parameters.
- Adds a valid/ready memory handshake with wait-state support, a zero-extend immediate mode (andi/ori), and a stall output to the controller FSM.
- Sits between the multicycle controller and the unified instruction/data memory.

Parameters:
- WIDTH, 32, datapath/register/address width; must be >= 32.
- NREGS, 32, register count; power of 2, 8..32; register address width RAW = log2(NREGS).
- MAXWAIT, 15, memory wait-state limit before error; counter width = clog2(MAXWAIT+1).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- pcen  in  1  PC write enable (already includes branch qualification)
- irwrite  in  1  capture instruction on memory completion
- regwrite  in  1  register file write
- alusrca, iord, memtoreg, regdst, extop  in  1 each  mux selects; extop 1 = zero-extend immediate
- alusrcb, pcsrc  in  2 each  mux selects (srcb: B, 4, ext, ext<<2; pc: aluresult, aluout, jump target)
- alucontrol  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- memstart  in  1  controller requests a memory access this cycle
- memwrite  in  1  access is a store (sampled with memstart)
- opcode  out  6  instr[31:26]
- funct  out  6  instr[5:0]
- zero  out  1  aluresult == 0
- stall  out  1  memory access in progress; controller holds state
- memerr  out  1  sticky timeout flag
- mem_req  out  1  request valid
- mem_we  out  1  write strobe, valid with mem_req
- adr  out  WIDTH  memory address
- writedata  out  WIDTH  B register
- readdata  in  WIDTH  memory read data
- mem_ready  in  1  memory accepts/completes the access

Behaviour:
- Reset (reset_n low, asynchronous): PC, IR, MDR, A, B, ALUOut, all registers = 0. Memory FSM goes to IDLE, mem_req = 0, mem_we = 0, stall = 0, memerr = 0. Reset mid-access aborts it; no IR/MDR update.
- Register 0 always reads 0. Writes to register 0 are discarded.
- Register file: two combinational read ports, write on rising edge when regwrite = 1. A and B load every cycle.
- ALUOut loads every cycle. zero is combinational from aluresult.
- Immediate extension: extop = 0 sign-extends immed[15:0] to WIDTH; extop = 1 zero-extends.
- Jump target = {pc[WIDTH-1:28], jmpimmed, 2'b00}.
- adr = iord ? ALUOut : PC.
- ALU is WIDTH-bit modular, carries discarded. SLT is a signed compare returning 1 or 0.
- Memory FSM states IDLE, REQ, DONE:
  - IDLE: on memstart, latch memwrite, go to REQ. stall = 1 in the same cycle (combinational from memstart).
  - REQ: mem_req = 1, mem_we = latched memwrite, adr held stable, stall = 1.
    - On mem_ready = 1 with a read: MDR <= readdata, and IR <= readdata if irwrite = 1. Go to DONE.
    - Wait counter increments each cycle mem_ready = 0. At MAXWAIT: set memerr, drop mem_req, go to DONE, no capture.
  - DONE: one cycle with stall = 0; return to IDLE. memstart in DONE is ignored (minimum one idle cycle between accesses).
- Zero-wait memory (mem_ready high in the first REQ cycle) gives 2-cycle access latency: memstart cycle plus REQ cycle.
- pcen and regwrite are gated off while stall = 1. The controller may hold them; they take effect in the cycle after stall falls.
- memerr clears only on reset.
- mem_ready outside REQ is ignored.

Decomposition:
- mips_decls_p package holds opcode_t, funct_t, alucontrol encoding enum alu_op_t, and memory FSM enum mem_state_t.
- Natural sub-module: mem_hs_fsm (handshake FSM + wait counter + memerr).
- Reuse existing flopenr, mux2, mux3, mux4 and alu.
- Register file generalised to regfile_p #(WIDTH, NREGS).

Test Plan:
- Reset with reset_n = 0 mid-REQ, checked asynchronously before the next clock edge → mem_req = 0, stall = 0, PC = 0, IR unchanged (0).
- Fetch, zero-wait: PC = 0, memstart = 1, irwrite = 1, readdata = 0x20080005, mem_ready = 1 → opcode = 0x08, stall high for exactly 2 cycles, then PC = 4 after pcen.
- Fetch with 3 wait states: mem_ready low 3 cycles → mem_req held 4 cycles, adr stable, IR captured only on the ready cycle.
- Timeout: mem_ready never asserted, MAXWAIT = 15 → memerr = 1 after 15 REQ cycles, IR unchanged, memerr stays 1 until reset.
- ori with extop = 1, immed = 0xFFFF, rs = 0 → rt = 0x0000FFFF. Same with extop = 0 via addi → 0xFFFFFFFF.
- Write to $0 with value 0x1234 → reads back 0. SLT 0xFFFFFFFF vs 1 → 1. SUB equal operands → zero = 1.
- WIDTH = 64, NREGS = 16 build: ADD 0xFFFFFFFF_FFFFFFFF + 1 → 0, zero = 1.
